mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates the CPU's single unified memory between the IF-stage fetch port (read-only) and the MEM-stage load/store port. Each cycle it issues at most one access to the synchronous single-port memory, which has a 1-cycle read latency. It routes read data back to the owning port one cycle later and produces per-port stall signals for the hazard unit. The data port has priority because it belongs to the older instruction. A streak limit prevents fetch starvation.

Parameters:
ADDR_W, 6, memory word-address width (64 words)
DATA_W, 32, data width
MAX_D_STREAK, 4, maximum consecutive data grants while if_req is pending before fetch is forced through

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  load/store request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data access accepted this cycle (combinational)
d_rvalid  out  1  d_rdata valid (loads only, cycle after d_gnt)
d_rdata  out  DATA_W  load data
d_misalign  out  1  registered pulse: accepted access had d_addr[1:0] != 0
stall_if  out  1  if_req & ~if_gnt
stall_mem  out  1  d_req & ~d_gnt
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  word address (byte addr[ADDR_W+1:2])
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Reset is synchronous and active-high. While rst is high, every output is 0, owner = NONE and streak = 0.
- Grant is combinational in the issue cycle:
  - d_gnt = d_req & ~force_if.
  - if_gnt = if_req & (~d_req | force_if).
  - force_if = if_req & (streak == MAX_D_STREAK).
- mem_* drives from the granted port in the same cycle. mem_en = if_gnt | (d_gnt & aligned).
- A misaligned data access is still granted and consumes the slot. It does not drive mem_en. d_misalign pulses the next cycle, and d_rvalid stays 0.
- Owner register, updated each cycle from the grant:
  - IF for an if_gnt.
  - DRD for an aligned load.
  - DWR for a store or a misaligned access.
  - NONE when nothing was granted.
- Response, the cycle after issue:
  - owner == IF: if_rvalid = 1, if_rdata = mem_rdata.
  - owner == DRD: d_rvalid = 1, d_rdata = mem_rdata.
  - Otherwise: rvalids are 0 and rdata holds its last value.
- Throughput is one access per cycle, back-to-back. A port may present a new request in the cycle after its gnt. The response of the previous request and the grant of the new one may coincide.
- Streak counter:
  - A d_gnt while if_req is high increments it, saturating at MAX_D_STREAK.
  - Any if_gnt, or a cycle with if_req low, clears it.
- After a forced fetch, data gets priority again next cycle.
- Simultaneous requests with streak < MAX: data wins, and stall_if = 1.
- No requests: mem_en = 0, owner = NONE.
- Reset mid-operation: a response pending for the next cycle is discarded. if_rvalid and d_rvalid stay 0, and requesters must reissue.
- A store followed by a load to the same address on the next cycle returns the new data. This relies on memory write-before-read ordering across cycles; no forwarding is done in the arbiter.

Decomposition:
- Shared package cpu_mem_pkg:
  - Owner encoding enum {OWN_NONE, OWN_IF, OWN_DRD, OWN_DWR}.
  - ADDR_W and DATA_W defaults.
  - Word-address slicing helper constant (byte offset bits = 2).
- One natural sub-module: arb_streak_ctr, the saturating streak counter that produces force_if.
- Everything else stays in mem_port_arbiter.

Test Plan:
- Reset: hold rst for 2 cycles with if_req = d_req = 1 -> all outputs 0. First grant appears in the cycle after rst falls: d_gnt = 1, if_gnt = 0.
- Fetch only: if_req with if_addr = 0x8, mem word 2 = 0x00802183 -> mem_addr = 2 and if_gnt in cycle t. if_rvalid = 1 with if_rdata = 0x00802183 in t+1.
- Conflict: both request; d_we = 0, d_addr = 0x4 -> d_gnt = 1, stall_if = 1, and d_rvalid next cycle. if_gnt follows one cycle later once d_req drops.
- Starvation: if_req and d_req held high continuously -> d_gnt for 4 cycles, if_gnt on the 5th, then d_gnt resumes. Repeating pattern 4:1.
- Store then load: sw 0xDEADBEEF to 0xC, then lw 0xC on the next cycle -> mem_we = 1 for one cycle, no d_rvalid for the store. Load gets d_rvalid with d_rdata = 0xDEADBEEF.
- Misaligned and reset mid-flight: d_addr = 0x6 -> d_gnt = 1, mem_en = 0, d_misalign pulse next cycle. Separately, assert rst the cycle after a fetch grant -> if_rvalid stays 0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter: owner encoding,
// default widths and byte-to-word address slicing.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_e;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants while a fetch waits; raises
// force_if once the limit is reached so the fetch port cannot starve.
module arb_streak_ctr #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_gnt,
  input  logic if_gnt,
  output logic force_if
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_reg <= '0;
    end else if (if_gnt || !if_req) begin
      streak_reg <= '0;
    end else if (d_gnt && (streak_reg != STREAK_MAX)) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end

  assign force_if = if_req && (streak_reg == STREAK_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between the fetch and load/store
// ports: data has priority, a streak limit forces fetches through.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_misalign,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int AHI = ADDR_W + BYTE_OFF_W - 1;

  owner_e            owner_reg, owner_next;
  logic              run;
  logic              force_if;
  logic              aligned;
  logic              misalign_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;
  logic              unused_addr_bits;

  assign run     = !rst;
  assign aligned = (d_addr[BYTE_OFF_W-1:0] == '0);

  arb_streak_ctr #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_streak (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .d_gnt   (d_gnt),
    .if_gnt  (if_gnt),
    .force_if(force_if)
  );

  assign d_gnt     = run && d_req && !force_if;
  assign if_gnt    = run && if_req && (!d_req || force_if);
  assign stall_if  = run && if_req && !if_gnt;
  assign stall_mem = run && d_req && !d_gnt;

  // A misaligned data grant still consumes the slot but never touches memory.
  assign mem_en    = if_gnt || (d_gnt && aligned);
  assign mem_we    = d_gnt && aligned && d_we;
  assign mem_wdata = mem_we ? d_wdata : '0;

  always_comb begin
    mem_addr = '0;
    if (if_gnt) begin
      mem_addr = if_addr[AHI:BYTE_OFF_W];
    end else if (d_gnt) begin
      mem_addr = d_addr[AHI:BYTE_OFF_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg <= OWN_NONE;
    end else begin
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt) begin
      owner_next = OWN_IF;
    end else if (d_gnt) begin
      owner_next = (aligned && !d_we) ? OWN_DRD : OWN_DWR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      misalign_reg <= d_gnt && !aligned;
      if (owner_reg == OWN_IF) begin
        if_rdata_reg <= mem_rdata;
      end
      if (owner_reg == OWN_DRD) begin
        d_rdata_reg <= mem_rdata;
      end
    end
  end

  // Gating by run drops any response that was pending when reset arrived.
  always_comb begin
    if_rvalid  = run && (owner_reg == OWN_IF);
    d_rvalid   = run && (owner_reg == OWN_DRD);
    d_misalign = run && misalign_reg;
    if_rdata   = '0;
    d_rdata    = '0;
    if (run) begin
      if_rdata = (owner_reg == OWN_IF) ? mem_rdata : if_rdata_reg;
      d_rdata  = (owner_reg == OWN_DRD) ? mem_rdata : d_rdata_reg;
    end
  end

  assign unused_addr_bits = ^{if_addr[31:AHI+1], if_addr[BYTE_OFF_W-1:0], d_addr[31:AHI+1]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64-word synchronous
// memory attached to the mem_* port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        d_misalign, stall_if, stall_mem;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [64];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_misalign(d_misalign),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[2] = 32'h0080_2183;

    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h8; d_addr = 32'h4; d_wdata = 32'h0;

    // Reset held two cycles with both ports requesting
    for (int r = 0; r < 2; r++) begin
      next_cycle(); sample();
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
      chk("rst_outs", {26'b0, mem_en, mem_we, stall_if, stall_mem, if_rvalid, d_rvalid}, 32'd0);
    end
    $display("txn reset: held 2 cycles");

    // Conflict: load 0x4 beats fetch 0x8
    next_cycle(); rst = 1'b0; sample();
    chk("conf_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("conf_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("conf_stall_if", {31'b0, stall_if}, 32'd1);
    chk("conf_mem_addr", {26'b0, mem_addr}, 32'd1);
    $display("txn conflict: load 0x4 granted, fetch stalled");

    next_cycle(); d_req = 1'b0; sample();
    chk("fetch_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("fetch_mem_addr", {26'b0, mem_addr}, 32'd2);
    chk("conf_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("conf_d_rdata", d_rdata, 32'hA000_0001);
    $display("txn load resp: d_rdata=%h", d_rdata);

    next_cycle(); if_req = 1'b0; sample();
    chk("fetch_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("fetch_if_rdata", if_rdata, 32'h0080_2183);
    chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
    $display("txn fetch resp: if_rdata=%h", if_rdata);

    // Starvation: both held, expect 4 data grants then 1 forced fetch
    next_cycle(); if_req = 1'b1; d_req = 1'b1; d_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      sample();
      chk("starve_if_gnt", {31'b0, if_gnt}, (k % 5 == 4) ? 32'd1 : 32'd0);
      chk("starve_d_gnt", {31'b0, d_gnt}, (k % 5 == 4) ? 32'd0 : 32'd1);
      $display("txn starve k=%0d: d_gnt=%0b if_gnt=%0b", k, d_gnt, if_gnt);
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0; sample();
    chk("starve_if_rvalid", {31'b0, if_rvalid}, 32'd1);

    // Store then load to 0xC
    next_cycle(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'hDEAD_BEEF; sample();
    chk("sw_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("sw_mem_we", {31'b0, mem_we}, 32'd1);
    chk("sw_mem_addr", {26'b0, mem_addr}, 32'd3);
    chk("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    $display("txn store: addr=0xC data=%h", mem_wdata);

    next_cycle(); d_we = 1'b0; sample();
    chk("lw_mem_we", {31'b0, mem_we}, 32'd0);
    chk("lw_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("sw_no_rvalid", {31'b0, d_rvalid}, 32'd0);

    next_cycle(); d_req = 1'b0; sample();
    chk("lw_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("lw_d_rdata", d_rdata, 32'hDEAD_BEEF);
    $display("txn load after store: d_rdata=%h", d_rdata);

    next_cycle(); sample();
    chk("hold_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("hold_d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Misaligned load at 0x6
    next_cycle(); d_req = 1'b1; d_addr = 32'h6; sample();
    chk("mis_d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("mis_mem_en", {31'b0, mem_en}, 32'd0);
    next_cycle(); d_req = 1'b0; sample();
    chk("mis_pulse", {31'b0, d_misalign}, 32'd1);
    chk("mis_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    next_cycle(); sample();
    chk("mis_pulse_end", {31'b0, d_misalign}, 32'd0);
    $display("txn misaligned: addr=0x6");

    // Reset the cycle after a fetch grant: response discarded
    next_cycle(); if_req = 1'b1; if_addr = 32'h8; sample();
    chk("rf_if_gnt", {31'b0, if_gnt}, 32'd1);
    next_cycle(); rst = 1'b1; if_req = 1'b0; sample();
    chk("rf_rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rf_rst_if_rdata", if_rdata, 32'd0);
    next_cycle(); rst = 1'b0; sample();
    chk("rf_post_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    $display("txn reset mid-flight: fetch response dropped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
